// File: rtl/goldschmidt_prenorm.sv
// Operand pre-normaliser feeding goldschmidt_div: shifts each operand left
// until bit WIDTH-2 is set, reporting shift counts and zero flags.
module goldschmidt_prenorm #(
    parameter int WIDTH = 30,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-2:0] num_in,
    input  logic [WIDTH-2:0] den_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] numerator,
    output logic [WIDTH-1:0] denominator,
    output logic [SW-1:0]    nshift,
    output logic [SW-1:0]    dshift,
    output logic             num_zero,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    logic   n_done;
    logic   d_done;

    // A zero operand has no leading one to find, so its flag stops it.
    assign n_done = numerator[WIDTH-2] | num_zero;
    assign d_done = denominator[WIDTH-2] | div_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            numerator   <= '0;
            denominator <= '0;
            nshift      <= '0;
            dshift      <= '0;
            num_zero    <= 1'b0;
            div_zero    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        numerator   <= {1'b0, num_in};
                        denominator <= {1'b0, den_in};
                        nshift      <= '0;
                        dshift      <= '0;
                        num_zero    <= (num_in == '0);
                        div_zero    <= (den_in == '0);
                        in_ready    <= 1'b0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (n_done && d_done) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (!n_done) begin
                            numerator <= numerator << 1;
                            nshift    <= nshift + SW'(1);
                        end
                        if (!d_done) begin
                            denominator <= denominator << 1;
                            dshift      <= dshift + SW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
